// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter sharing one single-beat memory port between fetch and data requesters.
// Optional MEM_BUS_ARB_RR_EN replaces fixed data-first priority with round-robin.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_data,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    output logic                m_is_write,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic                m_last,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [STRB_W-1:0]   strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                grant_data;
    logic                done;

    assign done = m_ready & m_last;

`ifdef MEM_BUS_ARB_RR_EN
    // 1 = fetch was granted last; the reset value of 0 lets fetch go first on a tie.
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_data   = d_valid;
        last_grant_d = last_grant_q;
        if (d_valid && i_valid) begin
            grant_data = last_grant_q;
        end
        if (state_q == StIdle && (d_valid || i_valid)) begin
            last_grant_d = ~grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign grant_data = d_valid;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strobe_d  = strobe_q;
        wdata_d   = wdata_q;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_data    = '0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = '0;
        case (state_q)
            StIdle: begin
                if (d_valid || i_valid) begin
                    if (grant_data) begin
                        state_d  = StBusyD;
                        addr_d   = d_addr;
                        size_d   = d_size;
                        strobe_d = d_strobe;
                        wdata_d  = d_wdata;
                    end else begin
                        state_d  = StBusyI;
                        addr_d   = i_addr;
                        size_d   = 3'b011;
                        strobe_d = '0;
                        wdata_d  = '0;
                    end
                end
            end
            StBusyI: begin
                if (done) begin
                    state_d   = StIdle;
                    i_addr_ok = 1'b1;
                    i_data_ok = 1'b1;
                    i_data    = m_rdata;
                end
            end
            StBusyD: begin
                if (done) begin
                    state_d   = StIdle;
                    d_addr_ok = 1'b1;
                    d_data_ok = 1'b1;
                    d_rdata   = m_rdata;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    assign m_valid    = (state_q != StIdle);
    assign m_is_write = |strobe_q;
    assign m_addr     = addr_q;
    assign m_size     = size_q;
    assign m_strobe   = strobe_q;
    assign m_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (default build: fixed data-over-fetch priority).
// Directed scenarios plus a randomized transaction-level run against a priority model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [63:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid, m_is_write;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_ready, m_last;
    logic [63:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_last(m_last),
        .m_rdata(m_rdata)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_size = '0;
        d_strobe = '0; d_wdata = '0; m_ready = 0; m_last = 0; m_rdata = '0;
        tick(); tick();
        #1;
        checks++;
        if ({m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got v=%0b w=%0b a=%h s=%0d st=%h wd=%h, want all 0",
                     m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata);
        end
        checks++;
        if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, i_data, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_oks: got ok=%b%b%b%b, want 0000",
                     i_addr_ok, i_data_ok, d_addr_ok, d_data_ok);
        end
        reset = 1'b0;
        tick(); #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        i_valid = 1; i_addr = 64'h8000_0000;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_not_yet: m_valid=%b want 0", m_valid);
        end
        tick(); #1;
        checks++;
        if (m_valid !== 1 || m_addr !== 64'h8000_0000 || m_size !== 3'd3 || m_strobe !== 0
            || m_is_write !== 0 || i_data_ok !== 0) begin
            errors++;
            $display("FAIL fetch_grant: v=%b a=%h s=%0d st=%h w=%b ok=%b, want 1 80000000 3 0 0 0",
                     m_valid, m_addr, m_size, m_strobe, m_is_write, i_data_ok);
        end
        tick();
        m_ready = 1; m_last = 1; m_rdata = 64'h0000_0013_0000_0093;
        #1;
        checks++;
        if (i_data_ok !== 1 || i_addr_ok !== 1 || i_data !== 64'h0000_0013_0000_0093
            || d_data_ok !== 0) begin
            errors++;
            $display("FAIL fetch_done: iok=%b iaok=%b data=%h dok=%b, want 1 1 0000001300000093 0",
                     i_data_ok, i_addr_ok, i_data, d_data_ok);
        end
        tick();
        m_ready = 0; m_last = 0; i_valid = 0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_release: m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_write_hold();
        d_valid = 1; d_addr = 64'h8000_1008; d_strobe = 8'hF0;
        d_wdata = 64'hDEAD_BEEF_0000_0000; d_size = 3'd2;
        tick(); #1;
        checks++;
        if (m_valid !== 1 || m_is_write !== 1 || m_addr !== 64'h8000_1008 || m_size !== 3'd2
            || m_strobe !== 8'hF0 || m_wdata !== 64'hDEAD_BEEF_0000_0000) begin
            errors++;
            $display("FAIL write_grant: v=%b w=%b a=%h s=%0d st=%h wd=%h", m_valid, m_is_write,
                     m_addr, m_size, m_strobe, m_wdata);
        end
        @(negedge clk);
        d_addr = '0; d_valid = 0;
        tick(); #1;
        checks++;
        if (m_addr !== 64'h8000_1008 || m_valid !== 1) begin
            errors++;
            $display("FAIL write_hold: a=%h v=%b want 80001008 1", m_addr, m_valid);
        end
        @(negedge clk);
        m_ready = 1; m_last = 1; m_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        checks++;
        if (d_data_ok !== 1 || d_addr_ok !== 1 || i_data_ok !== 0
            || d_rdata !== 64'h1234_5678_9ABC_DEF0 || i_data !== 0) begin
            errors++;
            $display("FAIL write_done: dok=%b daok=%b iok=%b rd=%h", d_data_ok, d_addr_ok,
                     i_data_ok, d_rdata);
        end
        tick();
        m_ready = 0; m_last = 0;
    endtask

    task automatic test_priority();
        i_valid = 1; i_addr = 64'h8000_0040;
        d_valid = 1; d_addr = 64'h8000_2000; d_strobe = 8'h00; d_size = 3'd3; d_wdata = '0;
        tick();
        m_ready = 1; m_last = 1; m_rdata = 64'hAAAA;
        #1;
        checks++;
        if (m_addr !== 64'h8000_2000 || d_data_ok !== 1 || i_data_ok !== 0) begin
            errors++;
            $display("FAIL prio_data_first: a=%h dok=%b iok=%b want 80002000 1 0",
                     m_addr, d_data_ok, i_data_ok);
        end
        tick();
        m_ready = 0; m_last = 0; d_valid = 0;
        #1;
        checks++;
        if (m_valid !== 0) begin
            errors++; $display("FAIL prio_bubble: m_valid=%b want 0", m_valid);
        end
        tick(); #1;
        checks++;
        if (m_valid !== 1 || m_addr !== 64'h8000_0040 || m_size !== 3'd3) begin
            errors++;
            $display("FAIL prio_fetch_next: v=%b a=%h s=%0d", m_valid, m_addr, m_size);
        end
        @(negedge clk);
        m_ready = 1; m_last = 1; m_rdata = 64'hBBBB;
        #1;
        checks++;
        if (i_data_ok !== 1 || i_data !== 64'hBBBB) begin
            errors++;
            $display("FAIL prio_fetch_done: iok=%b data=%h want 1 bbbb", i_data_ok, i_data);
        end
        tick();
        m_ready = 0; m_last = 0; i_valid = 0;
    endtask

    task automatic test_reset_mid();
        i_valid = 1; i_addr = 64'h8000_0100;
        tick();
        reset = 1; i_valid = 0;
        tick();
        reset = 0; m_ready = 1; m_last = 1; m_rdata = 64'hCCCC;
        #1;
        checks++;
        if (m_valid !== 0 || i_data_ok !== 0 || i_addr_ok !== 0 || d_data_ok !== 0) begin
            errors++;
            $display("FAIL reset_mid: v=%b iok=%b iaok=%b dok=%b want 0", m_valid, i_data_ok,
                     i_addr_ok, d_data_ok);
        end
        tick();
        m_ready = 0; m_last = 0;
        #1;
        checks++;
        if (m_valid !== 0) begin
            errors++; $display("FAIL reset_mid_idle: m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_partial_beat();
        i_valid = 1; i_addr = 64'h8000_0200;
        tick();
        m_ready = 1; m_last = 0;
        #1;
        checks++;
        if (i_data_ok !== 0 || i_addr_ok !== 0) begin
            errors++;
            $display("FAIL partial_no_ok: iok=%b iaok=%b want 0", i_data_ok, i_addr_ok);
        end
        tick(); #1;
        checks++;
        if (m_valid !== 1 || m_addr !== 64'h8000_0200) begin
            errors++;
            $display("FAIL partial_held: v=%b a=%h want 1 80000200", m_valid, m_addr);
        end
        m_last = 1; m_rdata = 64'hDDDD;
        #1;
        checks++;
        if (i_data_ok !== 1 || i_data !== 64'hDDDD) begin
            errors++;
            $display("FAIL partial_done: iok=%b data=%h want 1 dddd", i_data_ok, i_data);
        end
        tick();
        m_ready = 0; m_last = 0; i_valid = 0;
    endtask

    // Transaction-level model: whenever both are pending, data is served first;
    // each grant is followed by one idle bubble.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit          iv, dv, own_d;
            int          sel, w;
            logic [63:0] ia, da, dw, rd, ea, ew;
            logic [7:0]  ds, es;
            logic [2:0]  dz, ez;
            sel = $urandom_range(0, 2);
            iv = (sel != 1); dv = (sel != 0);
            ia = {$urandom, $urandom}; da = {$urandom, $urandom}; dw = {$urandom, $urandom};
            ds = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            dz = 3'($urandom_range(0, 3));
            i_valid = iv; i_addr = ia;
            d_valid = dv; d_addr = da; d_strobe = ds; d_wdata = dw; d_size = dz;
            while (iv || dv) begin
                own_d = dv;
                ea = own_d ? da : ia;
                ez = own_d ? dz : 3'd3;
                es = own_d ? ds : 8'h00;
                ew = own_d ? dw : 64'h0;
                tick(); #1;
                checks++;
                if (m_valid !== 1 || m_addr !== ea || m_size !== ez || m_strobe !== es
                    || m_wdata !== ew || m_is_write !== (es != 0)) begin
                    errors++;
                    $display("FAIL rand_grant[%0d]: a=%h s=%0d st=%h wd=%h w=%b want %h %0d %h %h",
                             t, m_addr, m_size, m_strobe, m_wdata, m_is_write, ea, ez, es, ew);
                end
                w = $urandom_range(0, 3);
                for (int k = 0; k < w; k++) begin
                    @(negedge clk);
                    m_ready = 1'($urandom_range(0, 1)); m_last = 0;
                    #1;
                    checks++;
                    if (m_valid !== 1 || i_data_ok !== 0 || d_data_ok !== 0) begin
                        errors++;
                        $display("FAIL rand_wait[%0d]: v=%b iok=%b dok=%b want 1 0 0",
                                 t, m_valid, i_data_ok, d_data_ok);
                    end
                end
                @(negedge clk);
                rd = {$urandom, $urandom};
                m_ready = 1; m_last = 1; m_rdata = rd;
                #1;
                checks++;
                if (d_data_ok !== own_d || d_addr_ok !== own_d || i_data_ok !== !own_d
                    || i_addr_ok !== !own_d || d_rdata !== (own_d ? rd : 64'h0)
                    || i_data !== (own_d ? 64'h0 : rd)) begin
                    errors++;
                    $display("FAIL rand_done[%0d]: dok=%b iok=%b rd=%h id=%h own_d=%b",
                             t, d_data_ok, i_data_ok, d_rdata, i_data, own_d);
                end
                tick();
                m_ready = 0; m_last = 0; m_rdata = {$urandom, $urandom};
                if (own_d) begin
                    dv = 0; d_valid = 0;
                end else begin
                    iv = 0; i_valid = 0;
                end
                #1;
                checks++;
                if (m_valid !== 0) begin
                    errors++;
                    $display("FAIL rand_bubble[%0d]: m_valid=%b want 0", t, m_valid);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_hold();
        test_priority();
        test_reset_mid();
        test_partial_beat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
